// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Bundle of the fetch unit's bus signals. It covers the
//                instruction-memory request/response port and the
//                instruction/control port toward the control unit and
//                datapath.
//                  master : the fetch unit. It drives the memory request and
//                           the held instruction, and receives the memory
//                           response and the retire controls.
//                  slave  : memory plus downstream (the opposite directions).
//  Signals     : imem_req_valid/imem_req_ready/imem_addr  fetch request
//                imem_rsp_valid/imem_rsp_data             fetch response
//                instr_valid/instr_ready                  retire handshake
//                instr/opcode/funct/pc/pc_plus4           held instruction
//                branch_taken/jump                        next-PC select
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
    // instruction memory side
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    // control unit / datapath side
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic        jump;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, opcode, funct, pc, pc_plus4,
        input  instr_ready, branch_taken, jump
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, opcode, funct, pc, pc_plus4,
        output instr_ready, branch_taken, jump
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction-fetch sequencer. It owns the PC and issues one
//                word fetch at a time over a valid/ready request port. It
//                captures the response and holds the instruction, split into
//                opcode/funct, until the downstream side retires it. On
//                retire it moves the PC to PC+4, the branch target or the
//                jump target. Jump has priority over branch.
//                Sequence: S_RST -> S_REQ -> S_WAIT -> S_HOLD -> S_REQ ...
//  Ports       : clk           rising-edge clock
//                rst_n         asynchronous active-low reset
//                bus           instr_fetch_unit_if.master (memory + retire)
//                retire_count  [FETCH_COUNT_EN] retired instructions (wraps)
//                stall_cycles  [FETCH_COUNT_EN] request/hold stall cycles
//                              (saturates)
//  Options     : `define FETCH_COUNT_EN to add the two counter outputs.
//  Parameters  : RESET_PC      first fetch address; bits [1:0] are forced 0
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    instr_fetch_unit_if.master     bus
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]            retire_count,
    output logic [31:0]            stall_cycles
`endif
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;
    logic        retire;

    // ------------------------------------------------------------------
    // Next-PC arithmetic. All sums wrap modulo 2^32.
    // ------------------------------------------------------------------
    assign pc_plus4   = pc_q + 32'd4;
    assign br_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_target  = pc_plus4 + br_offset;
    // The jump stays inside the 256 MB region of the following instruction.
    assign jmp_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (bus.jump) begin
            next_pc = jmp_target;
        end else if (bus.branch_taken) begin
            next_pc = br_target;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            pc_q    <= PC_INIT;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A response is accepted only in S_WAIT. S_WAIT is
    // entered on the request handshake, so a response in that same cycle
    // (or at any other time) is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_RST: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    instr_d = bus.imem_rsp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.instr_ready) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    assign retire = (state_q == S_HOLD) && bus.instr_ready;

    // ------------------------------------------------------------------
    // Outputs. The two valids depend on the state register only.
    // ------------------------------------------------------------------
    assign bus.imem_req_valid = (state_q == S_REQ);
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = (state_q == S_HOLD);
    assign bus.instr          = instr_q;
    assign bus.opcode         = instr_q[31:26];
    assign bus.funct          = instr_q[5:0];
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_plus4;

`ifdef FETCH_COUNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] retire_count_q;
    logic [31:0] stall_cycles_q;
    logic        stall;

    assign stall = ((state_q == S_REQ)  && !bus.imem_req_ready) ||
                   ((state_q == S_HOLD) && !bus.instr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count_q <= 32'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            if (retire) begin
                retire_count_q <= retire_count_q + 32'd1;
            end
            if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign retire_count = retire_count_q;
    assign stall_cycles = stall_cycles_q;
`else
    // The retire term is only consumed by the counters.
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. The memory and
//                downstream sides are driven from tasks. Expected fetch
//                addresses are queued whenever a retire decides the next
//                PC, and each is popped when the DUT presents its next
//                request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

`ifdef FETCH_COUNT_EN
    logic [31:0] retire_count;
    logic [31:0] stall_cycles;
`endif

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_COUNT_EN
        ,
        .retire_count (retire_count),
        .stall_cycles (stall_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;
    logic [31:0] exp_addr_q [$];

    // Inputs change 1 ns after the rising edge, so the negedge sees exactly
    // what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) hs_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus only: wait (bounded) for a request and accept it at once,
    // then answer one cycle later. The DUT is left in S_HOLD.
    task automatic serve_fetch(input logic [31:0] data,
                               output logic [31:0] addr, output bit to);
        int n = 0;
        to   = 1'b0;
        addr = 32'hx;
        while (!bus.imem_req_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.imem_req_valid) begin
            to = 1'b1;
            return;
        end
        addr = bus.imem_addr;
        bus.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic retire(input logic br, input logic jmp);
        bus.instr_ready  = 1'b1;
        bus.branch_taken = br;
        bus.jump         = jmp;
        @(posedge clk); #1;
        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
    endtask

    task automatic test_reset();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.instr_ready    = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.jump           = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", bus.imem_req_valid); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.pc); end
        checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr); end
`ifdef FETCH_COUNT_EN
        checks++; if (retire_count !== 32'h0 || stall_cycles !== 32'h0) begin failures++; $display("FAIL reset_counters got=%h/%h exp=0/0", retire_count, stall_cycles); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;   // S_RST -> S_REQ
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got valid=%0b addr=%h exp 1/0", bus.imem_req_valid, bus.imem_addr); end
        exp_addr_q.push_back(32'h0000_0000);
    endtask

    task automatic test_basic_fetch();
        logic [31:0] a, e;
        bit to;
        serve_fetch(32'h0000_0020, a, to);
        checks++; if (to) begin failures++; $display("FAIL basic_req_timeout got=timeout exp=request"); end
        e = exp_addr_q.pop_front();
        checks++; if (a !== e) begin failures++; $display("FAIL basic_addr got=%h exp=%h", a, e); end
        // Two cycles after the request was seen: REQ, WAIT, then HOLD.
        checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL basic_instr_valid got=%0b exp=1", bus.instr_valid); end
        checks++; if (bus.opcode !== 6'h00 || bus.funct !== 6'h20) begin failures++; $display("FAIL basic_fields got=%h/%h exp=00/20", bus.opcode, bus.funct); end
        checks++; if (bus.pc !== 32'h0 || bus.pc_plus4 !== 32'h4) begin failures++; $display("FAIL basic_pc got=%h/%h exp=0/4", bus.pc, bus.pc_plus4); end
        retire(1'b0, 1'b0);
        exp_addr_q.push_back(32'h0000_0004);
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL basic_after_retire got iv=%0b rv=%0b exp 0/1", bus.instr_valid, bus.imem_req_valid); end
    endtask

    task automatic test_req_stall();
        logic [31:0] e;
        int hs0;
`ifdef FETCH_COUNT_EN
        logic [31:0] st0;
        st0 = stall_cycles;
`endif
        hs0 = hs_cnt;
        e = exp_addr_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== e) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0b/%h exp=1/%h", i, bus.imem_req_valid, bus.imem_addr, e); end
            @(posedge clk); #1;
        end
        bus.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        checks++; if (hs_cnt - hs0 !== 1) begin failures++; $display("FAIL stall_handshakes got=%0d exp=1", hs_cnt - hs0); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_wait_req got=%0b exp=0", bus.imem_req_valid); end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0800_0010;   // j 0x40
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0800_0010) begin failures++; $display("FAIL stall_instr got=%0b/%h exp=1/08000010", bus.instr_valid, bus.instr); end
`ifdef FETCH_COUNT_EN
        checks++; if (stall_cycles - st0 !== 32'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", stall_cycles - st0); end
`endif
        retire(1'b0, 1'b1);
        exp_addr_q.push_back(32'h0000_0040);
    endtask

    task automatic test_branch();
        logic [31:0] a, e;
        bit to;
        // beq with offset -2 at 0x40, taken
        serve_fetch(32'h1000_FFFE, a, to);
        e = exp_addr_q.pop_front();
        checks++; if (to || a !== e) begin failures++; $display("FAIL br_taken_addr got=%h to=%0b exp=%h", a, to, e); end
        checks++; if (bus.opcode !== 6'h04 || bus.pc !== 32'h40) begin failures++; $display("FAIL br_fields got=%h/%h exp=04/40", bus.opcode, bus.pc); end
        retire(1'b1, 1'b0);
        exp_addr_q.push_back(32'h0000_003C);
        // back to 0x40 via a jump
        serve_fetch(32'h0800_0010, a, to);
        e = exp_addr_q.pop_front();
        checks++; if (to || a !== e) begin failures++; $display("FAIL br_target_addr got=%h to=%0b exp=%h", a, to, e); end
        retire(1'b0, 1'b1);
        exp_addr_q.push_back(32'h0000_0040);
        // same beq, not taken
        serve_fetch(32'h1000_FFFE, a, to);
        e = exp_addr_q.pop_front();
        checks++; if (to || a !== e) begin failures++; $display("FAIL br_rejump_addr got=%h to=%0b exp=%h", a, to, e); end
        retire(1'b0, 1'b0);
        exp_addr_q.push_back(32'h0000_0044);
    endtask

    task automatic test_jump();
        logic [31:0] a, e;
        bit to;
        serve_fetch(32'h0BFF_FFFF, a, to);   // j to top of region 0
        e = exp_addr_q.pop_front();
        checks++; if (to || a !== e) begin failures++; $display("FAIL br_not_taken_addr got=%h to=%0b exp=%h", a, to, e); end
        retire(1'b0, 1'b1);
        exp_addr_q.push_back(32'h0FFF_FFFC);
        serve_fetch(32'h0000_0000, a, to);   // nop
        e = exp_addr_q.pop_front();
        checks++; if (to || a !== e) begin failures++; $display("FAIL jmp_region_top got=%h to=%0b exp=%h", a, to, e); end
        checks++; if (bus.pc_plus4 !== 32'h1000_0000) begin failures++; $display("FAIL jmp_pc_plus4 got=%h exp=10000000", bus.pc_plus4); end
        retire(1'b0, 1'b0);
        exp_addr_q.push_back(32'h1000_0000);
        serve_fetch(32'h0800_0010, a, to);
        e = exp_addr_q.pop_front();
        checks++; if (to || a !== e) begin failures++; $display("FAIL jmp_cross_addr got=%h to=%0b exp=%h", a, to, e); end
        retire(1'b1, 1'b1);                  // jump beats branch
        exp_addr_q.push_back(32'h1000_0040);
    endtask

    task automatic test_spurious();
        logic [31:0] e;
`ifdef FETCH_COUNT_EN
        logic [31:0] st0;
        st0 = stall_cycles;
`endif
        e = exp_addr_q.pop_front();
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== e) begin failures++; $display("FAIL prio_addr got=%0b/%h exp=1/%h", bus.imem_req_valid, bus.imem_addr, e); end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;                  // response while in S_REQ
        checks++; if (bus.instr !== 32'h0800_0010 || bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL spur_req got=%h/%0b exp=08000010/1", bus.instr, bus.imem_req_valid); end
        bus.imem_req_ready = 1'b1;           // response coincides with handshake
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0800_0010) begin failures++; $display("FAIL spur_same_cycle got=%0b/%h exp=0/08000010", bus.instr_valid, bus.instr); end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0022;
        @(posedge clk); #1;
        checks++; if (bus.instr_valid !== 1'b1 || bus.funct !== 6'h22) begin failures++; $display("FAIL spur_real_rsp got=%0b/%h exp=1/22", bus.instr_valid, bus.funct); end
        bus.imem_rsp_data = 32'hDEAD_BEEF;   // still valid, now in S_HOLD
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.instr !== 32'h0000_0022 || bus.pc !== e || bus.instr_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got instr=%h pc=%h iv=%0b rv=%0b exp 00000022/%h/1/0", i, bus.instr, bus.pc, bus.instr_valid, bus.imem_req_valid, e);
            end
        end
        bus.imem_rsp_valid = 1'b0;
`ifdef FETCH_COUNT_EN
        checks++; if (stall_cycles - st0 !== 32'd6) begin failures++; $display("FAIL spur_stall_count got=%0d exp=6", stall_cycles - st0); end
`endif
        retire(1'b0, 1'b0);
        exp_addr_q.push_back(32'h1000_0044);
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] a, e;
        bit to;
        e = exp_addr_q.pop_front();
        checks++; if (bus.imem_addr !== e) begin failures++; $display("FAIL rw_addr got=%h exp=%h", bus.imem_addr, e); end
        bus.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;           // now in S_WAIT
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 32'h0 || bus.instr !== 32'h0) begin
            failures++;
            $display("FAIL rw_async_clear got rv=%0b iv=%0b pc=%h instr=%h exp 0/0/0/0", bus.imem_req_valid, bus.instr_valid, bus.pc, bus.instr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;           // late response
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr !== 32'h0) begin failures++; $display("FAIL rw_restart got=%0b/%h/%h exp=1/0/0", bus.imem_req_valid, bus.imem_addr, bus.instr); end
        @(posedge clk); #1;
        checks++; if (bus.instr !== 32'h0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rw_late_rsp got=%h/%0b exp=0/0", bus.instr, bus.instr_valid); end
        bus.imem_rsp_valid = 1'b0;
        exp_addr_q.push_back(32'h0000_0000);
        serve_fetch(32'h0000_0020, a, to);
        e = exp_addr_q.pop_front();
        checks++; if (to || a !== e || bus.instr !== 32'h0000_0020) begin failures++; $display("FAIL rw_refetch got=%h/%h to=%0b exp=%h/00000020", a, bus.instr, to, e); end
        retire(1'b0, 1'b0);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h4) begin failures++; $display("FAIL rw_next got=%0b/%h exp=1/4", bus.imem_req_valid, bus.imem_addr); end
`ifdef FETCH_COUNT_EN
        checks++; if (retire_count !== 32'd1) begin failures++; $display("FAIL rw_retire_count got=%0d exp=1", retire_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_req_stall();
        test_branch();
        test_jump();
        test_spurious();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
